// File: rtl/logic_op_pkg.sv
// Shared definitions for logic_op_pipe: the logic operation encoding carried
// with every transaction and decoded per lane.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_lane.sv
// Combinational single-lane logic primitive: applies one of the eight
// two-input operations to a WIDTH-bit operand pair, or outputs zero when disabled.
module logic_op_lane
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operation decode; a disabled lane is forced to zero regardless of op.
  always_comb begin
    y = {WIDTH{1'b0}};
    if (en) begin
      case (op)
        OP_AND:    y = a & b;
        OP_OR:     y = a | b;
        OP_XOR:    y = a ^ b;
        OP_NAND:   y = ~(a & b);
        OP_NOR:    y = ~(a | b);
        OP_XNOR:   y = ~(a ^ b);
        OP_PASS_A: y = a;
        OP_NOT_A:  y = ~a;
        default:   y = {WIDTH{1'b0}};
      endcase
    end else begin
      y = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready multi-lane logic unit with saturating output counter.
// Optional per-lane AND-reduction output is enabled by defining LOGIC_OP_REDUCE_EN.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_op,
  input  logic [LANES-1:0]       in_lane_en,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_op,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic [CNT_W-1:0]       txn_count
`ifdef LOGIC_OP_REDUCE_EN
  ,
  output logic [LANES-1:0]       out_red_and
`endif
);

  localparam int DW = LANES * WIDTH;

  logic            s1_valid_q, s1_valid_d;
  logic [OP_W-1:0] s1_op_q, s1_op_d;
  logic [LANES-1:0] s1_en_q, s1_en_d;
  logic [DW-1:0]   s1_a_q, s1_a_d;
  logic [DW-1:0]   s1_b_q, s1_b_d;
  logic            s2_valid_q, s2_valid_d;
  logic [OP_W-1:0] s2_op_q, s2_op_d;
  logic [DW-1:0]   s2_y_q, s2_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          s2_free_s, in_hs_s, s1_adv_s, out_hs_s;
  logic [DW-1:0] lane_y_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic_op_lane #(.WIDTH(WIDTH)) u_lane (
      .op (op_e'(s1_op_q)),
      .en (s1_en_q[i]),
      .a  (s1_a_q[i*WIDTH +: WIDTH]),
      .b  (s1_b_q[i*WIDTH +: WIDTH]),
      .y  (lane_y_s[i*WIDTH +: WIDTH])
    );
  end

  // Handshake decode and next-state for both stages and the counter.
  always_comb begin
    s2_free_s  = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s2_free_s;
    in_hs_s    = in_valid && in_ready;
    s1_adv_s   = s1_valid_q && s2_free_s;
    out_hs_s   = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_en_d    = s1_en_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_op_d    = s2_op_q;
    s2_y_d     = s2_y_q;
    cnt_d      = cnt_q;

    if (in_hs_s) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_en_d    = in_lane_en;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // An S1 advance refills S2 even when its old contents leave this cycle.
    if (s1_adv_s) begin
      s2_valid_d = 1'b1;
      s2_op_d    = s1_op_q;
      s2_y_d     = lane_y_s;
    end else if (out_hs_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (out_hs_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= {OP_W{1'b0}};
      s1_en_q    <= {LANES{1'b0}};
      s1_a_q     <= {DW{1'b0}};
      s1_b_q     <= {DW{1'b0}};
      s2_valid_q <= 1'b0;
      s2_op_q    <= {OP_W{1'b0}};
      s2_y_q     <= {DW{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_en_q    <= s1_en_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_y_q     <= s2_y_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_op    = s2_op_q;
  assign out_y     = s2_y_q;
  assign txn_count = cnt_q;

`ifdef LOGIC_OP_REDUCE_EN
  logic [LANES-1:0] red_q, red_d;

  // Reduction is captured with the lane results so it always matches out_y.
  always_comb begin
    red_d = red_q;
    if (s1_adv_s) begin
      for (int i = 0; i < LANES; i++) begin
        red_d[i] = &lane_y_s[i*WIDTH +: WIDTH];
      end
    end else begin
      red_d = red_q;
    end
  end

  // Reduction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q <= {LANES{1'b0}};
    end else begin
      red_q <= red_d;
    end
  end

  assign out_red_and = red_q;
`endif

endmodule
